humidity_poll_scheduler: RTL and testbench

// Sequences the humidity sensor reader. Issues its start strobe periodically or on demand, and watches the sensor data line for bit activity.

---
 rtl/humidity_poll_if.sv | 28 ++
 rtl/humidity_poll_scheduler.sv | 147 ++++++++++++++
 tb/tb_humidity_poll_scheduler.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/humidity_poll_if.sv
// Signal bundle between the humidity poll scheduler and its surroundings:
// reader inputs, the start strobe, and the published reading.
interface humidity_poll_if;
  logic        req_now;
  logic        data_line;
  logic [39:0] frame;
  logic        flag_five_sec;
  logic [7:0]  hum_int;
  logic [7:0]  hum_dec;
  logic [7:0]  temp_int;
  logic [7:0]  temp_dec;
  logic        data_valid;
  logic        new_sample;
  logic [7:0]  err_count;
  logic        busy;

  modport master (
    output req_now, data_line, frame,
    input  flag_five_sec, hum_int, hum_dec, temp_int, temp_dec,
           data_valid, new_sample, err_count, busy
  );

  modport slave (
    input  req_now, data_line, frame,
    output flag_five_sec, hum_int, hum_dec, temp_int, temp_dec,
           data_valid, new_sample, err_count, busy
  );
endinterface

// File: rtl/humidity_poll_scheduler.sv
// Humidity sensor poll sequencer: periodic/on-demand start strobe, edge-counted
// settle window, checksum validation, and retry with backoff on bad frames.
module humidity_poll_scheduler #(
  parameter int unsigned PERIOD_US    = 5000000,
  parameter int unsigned STROBE_LEN   = 4,
  parameter int unsigned SETTLE_US    = 30000,
  parameter int unsigned RETRY_GAP_US = 1000000,
  parameter int unsigned MAX_RETRY    = 2,
  parameter int unsigned MIN_EDGES    = 41
) (
  input  logic            clk1M,
  input  logic            rst,
  humidity_poll_if.slave  bus
);

  localparam logic [5:0] MIN_EDGES_L = 6'(MIN_EDGES);
  localparam logic [7:0] MAX_RETRY_L = 8'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG,
    S_WAIT,
    S_CHECK,
    S_BACKOFF
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_period;
  logic [31:0] r_phase;
  logic [5:0]  r_edges;
  logic [7:0]  r_retry;
  logic [7:0]  r_err;
  logic        r_data_d;
  logic [7:0]  r_hum_int;
  logic [7:0]  r_hum_dec;
  logic [7:0]  r_temp_int;
  logic [7:0]  r_temp_dec;
  logic        r_valid;
  logic        r_new;

  logic        w_period_hit;
  logic        w_enter_trig;
  logic        w_enter_backoff;
  logic        w_fall;
  logic [7:0]  w_sum;
  logic        w_pass;

  assign w_period_hit    = (r_period == PERIOD_US - 1);
  assign w_enter_trig    = (w_next == S_TRIG) && (r_state != S_TRIG);
  assign w_enter_backoff = (w_next == S_BACKOFF) && (r_state != S_BACKOFF);
  assign w_fall          = r_data_d & ~bus.data_line;
  assign w_sum           = bus.frame[39:32] + bus.frame[31:24]
                         + bus.frame[23:16] + bus.frame[15:8];
  assign w_pass          = (r_edges >= MIN_EDGES_L) && (bus.frame[7:0] == w_sum)
                         && (bus.frame != '0);

  // NOTE: next state gets its default before the case so no path infers a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_period_hit || bus.req_now) w_next = S_TRIG;
      S_TRIG:    if (r_phase == STROBE_LEN - 1) w_next = S_WAIT;
      S_WAIT:    if (r_phase == SETTLE_US - 1) w_next = S_CHECK;
      S_CHECK: begin
        if (w_pass)                    w_next = S_IDLE;
        else if (r_retry < MAX_RETRY_L) w_next = S_BACKOFF;
        else                           w_next = S_IDLE;
      end
      S_BACKOFF: if (r_phase == RETRY_GAP_US - 1) w_next = S_TRIG;
      default:   w_next = S_IDLE;
    endcase
  end

  // NOTE: all state registers use non-blocking assignment so every register
  // sees the pre-edge values of the others.
  always_ff @(posedge clk1M or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_period <= '0;
      r_phase  <= '0;
      r_edges  <= '0;
      r_data_d <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_data_d <= bus.data_line;

      // A missed expiry parks the counter so the poll fires once back in IDLE.
      if (w_enter_trig)       r_period <= '0;
      else if (!w_period_hit) r_period <= r_period + 32'd1;

      // Phase runs continuously from strobe start to sampling, and through backoff.
      if (w_enter_trig || w_enter_backoff)
        r_phase <= '0;
      else if (r_state == S_TRIG || r_state == S_WAIT || r_state == S_BACKOFF)
        r_phase <= r_phase + 32'd1;
      else
        r_phase <= '0;

      if (r_state == S_TRIG)
        r_edges <= '0;
      else if (r_state == S_WAIT && w_fall && r_edges != 6'd63)
        r_edges <= r_edges + 6'd1;
    end
  end

  always_ff @(posedge clk1M or posedge rst) begin
    if (rst) begin
      r_retry    <= '0;
      r_err      <= '0;
      r_hum_int  <= '0;
      r_hum_dec  <= '0;
      r_temp_int <= '0;
      r_temp_dec <= '0;
      r_valid    <= 1'b0;
      r_new      <= 1'b0;
    end else begin
      r_new <= 1'b0;
      if (r_state == S_CHECK) begin
        if (w_pass) begin
          r_hum_int  <= bus.frame[39:32];
          r_hum_dec  <= bus.frame[31:24];
          r_temp_int <= bus.frame[23:16];
          r_temp_dec <= bus.frame[15:8];
          r_valid    <= 1'b1;
          r_new      <= 1'b1;
          r_retry    <= '0;
        end else begin
          if (r_err != 8'hFF) r_err <= r_err + 8'd1;
          if (r_retry < MAX_RETRY_L) r_retry <= r_retry + 8'd1;
          else                      r_retry <= '0;
        end
      end
    end
  end

  assign bus.flag_five_sec = (r_state == S_TRIG);
  assign bus.busy          = (r_state != S_IDLE);
  assign bus.hum_int       = r_hum_int;
  assign bus.hum_dec       = r_hum_dec;
  assign bus.temp_int      = r_temp_int;
  assign bus.temp_dec      = r_temp_dec;
  assign bus.data_valid    = r_valid;
  assign bus.new_sample    = r_new;
  assign bus.err_count     = r_err;

endmodule

// File: tb/tb_humidity_poll_scheduler.sv
// Directed bench for humidity_poll_scheduler with a small sensor model that
// produces a configurable number of data-line falling edges after each strobe.
module tb_humidity_poll_scheduler;

  localparam int unsigned PERIOD = 1000;
  localparam int unsigned SETTLE = 100;
  localparam int unsigned GAP    = 200;

  logic clk1M = 1'b0;
  logic rst;

  humidity_poll_if dut_if ();

  humidity_poll_scheduler #(
    .PERIOD_US    (PERIOD),
    .STROBE_LEN   (4),
    .SETTLE_US    (SETTLE),
    .RETRY_GAP_US (GAP),
    .MAX_RETRY    (2),
    .MIN_EDGES    (41)
  ) u_dut (
    .clk1M (clk1M),
    .rst   (rst),
    .bus   (dut_if.slave)
  );

  always #5 clk1M = ~clk1M;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_strobes = 0;
  int n_new    = 0;
  int t_rise   = 0;
  int t_new    = 0;
  int width    = 0;
  int n_edges  = 41;
  logic prev_flag = 1'b0;

  // Cycle counter plus strobe/new_sample observer, sampled 1 unit after the edge.
  always @(posedge clk1M) begin
    cyc = cyc + 1;
    #1;
    if (dut_if.flag_five_sec && !prev_flag) begin
      n_strobes = n_strobes + 1;
      t_rise    = cyc;
    end
    if (!dut_if.flag_five_sec && prev_flag) width = cyc - t_rise;
    prev_flag = dut_if.flag_five_sec;
    if (dut_if.new_sample) begin
      n_new = n_new + 1;
      t_new = cyc;
    end
  end

  // Sensor model: once the strobe ends, emit n_edges falling edges, one per 2 cycles.
  initial begin
    dut_if.data_line = 1'b1;
    forever begin
      @(negedge clk1M);
      if (dut_if.flag_five_sec) begin
        for (int w = 0; w < 16 && dut_if.flag_five_sec; w++) @(negedge clk1M);
        for (int e = 0; e < n_edges; e++) begin
          dut_if.data_line = 1'b0;
          @(negedge clk1M);
          dut_if.data_line = 1'b1;
          @(negedge clk1M);
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk1M);
  endtask

  task automatic wait_rise(input string tag, input int budget);
    int start = n_strobes;
    int k = 0;
    while (n_strobes == start && k < budget) begin
      @(negedge clk1M);
      k++;
    end
    check({tag, "_strobe_seen"}, 64'(n_strobes != start), 64'd1);
  endtask

  task automatic wait_new(input string tag, input int budget);
    int start = n_new;
    int k = 0;
    while (n_new == start && k < budget) begin
      @(negedge clk1M);
      k++;
    end
    check({tag, "_new_seen"}, 64'(n_new != start), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int t0, r1, r2, r3, r4, r5, r6, r7, rq, rc, rc2, r8, r9, r10, r11, tq, sc, nn;

  initial begin
    rst = 1'b1;
    dut_if.req_now = 1'b0;
    dut_if.frame   = '0;
    repeat (3) @(negedge clk1M);

    // Reset state
    check("rst_flag",   64'(dut_if.flag_five_sec), 64'd0);
    check("rst_busy",   64'(dut_if.busy),          64'd0);
    check("rst_valid",  64'(dut_if.data_valid),    64'd0);
    check("rst_err",    64'(dut_if.err_count),     64'd0);
    check("rst_hum",    64'(dut_if.hum_int),       64'd0);
    check("rst_new",    64'(dut_if.new_sample),    64'd0);

    // Periodic poll with a good frame: 0x37+0x00+0x19+0x00 = 0x50
    dut_if.frame = 40'h37_00_19_00_50;
    rst = 1'b0;
    t0  = cyc;
    wait_rise("p1", PERIOD + 100);
    check("p1_time", 64'(t_rise - t0), 64'd1000);
    r1 = t_rise;
    wait_new("p1", 200);
    check("p1_new_time", 64'(t_new - r1), 64'd101);
    check("p1_width",    64'(width),      64'd4);
    check("p1_hum_int",  64'(dut_if.hum_int),  64'h37);
    check("p1_hum_dec",  64'(dut_if.hum_dec),  64'h00);
    check("p1_temp_int", 64'(dut_if.temp_int), 64'h19);
    check("p1_temp_dec", 64'(dut_if.temp_dec), 64'h00);
    check("p1_valid",    64'(dut_if.data_valid), 64'd1);
    check("p1_err",      64'(dut_if.err_count),  64'd0);
    @(negedge clk1M);
    check("p1_new_pulse_end", 64'(dut_if.new_sample), 64'd0);
    check("p1_idle_busy",     64'(dut_if.busy),       64'd0);
    wait_rise("p2", PERIOD + 100);
    check("p2_period", 64'(t_rise - r1), 64'd1000);
    r2 = t_rise;
    wait_new("p2", 200);

    // Bad checksum twice, then good on the second retry
    dut_if.frame = 40'h37_00_19_00_61;
    wait_rise("p3", PERIOD + 100);
    check("p3_period", 64'(t_rise - r2), 64'd1000);
    r3 = t_rise;
    wait_rise("p3_retry1", 400);
    check("p3_retry1_gap", 64'(t_rise - r3), 64'd301);
    check("p3_retry1_err", 64'(dut_if.err_count), 64'd1);
    check("p3_retry1_busy", 64'(dut_if.busy), 64'd1);
    r4 = t_rise;
    wait_rise("p3_retry2", 400);
    check("p3_retry2_gap", 64'(t_rise - r4), 64'd301);
    check("p3_retry2_err", 64'(dut_if.err_count), 64'd2);
    check("p3_held_hum",   64'(dut_if.hum_int), 64'h37);
    r5 = t_rise;
    // 0x41+0x05+0x20+0x0A = 0x70
    dut_if.frame = 40'h41_05_20_0A_70;
    wait_new("p3_final", 200);
    check("p3_new_time",  64'(t_new - r5), 64'd101);
    check("p3_hum_int",   64'(dut_if.hum_int),  64'h41);
    check("p3_hum_dec",   64'(dut_if.hum_dec),  64'h05);
    check("p3_temp_int",  64'(dut_if.temp_int), 64'h20);
    check("p3_temp_dec",  64'(dut_if.temp_dec), 64'h0A);
    check("p3_err_final", 64'(dut_if.err_count), 64'd2);

    // Stale frame: valid bytes but only 10 edges
    n_edges = 10;
    wait_rise("p4", PERIOD + 100);
    check("p4_period", 64'(t_rise - r5), 64'd1000);
    r6 = t_rise;
    nn = n_new;
    wait_cycles(110);
    check("p4_err",     64'(dut_if.err_count), 64'd3);
    check("p4_hum",     64'(dut_if.hum_int),   64'h41);
    check("p4_valid",   64'(dut_if.data_valid), 64'd1);
    check("p4_backoff", 64'(dut_if.busy),      64'd1);
    check("p4_no_new",  64'(n_new - nn),       64'd0);
    n_edges = 41;
    wait_rise("p4_retry", 400);
    check("p4_retry_gap", 64'(t_rise - r6), 64'd301);
    r7 = t_rise;
    wait_new("p4_retry", 200);
    check("p4_retry_new_time", 64'(t_new - r7), 64'd101);
    check("p4_retry_err",      64'(dut_if.err_count), 64'd3);

    // req_now in IDLE: strobe on the very next cycle
    wait_cycles(50);
    sc = n_strobes;
    dut_if.req_now = 1'b1;
    tq = cyc;
    @(negedge clk1M);
    dut_if.req_now = 1'b0;
    check("req_count", 64'(n_strobes - sc), 64'd1);
    check("req_time",  64'(t_rise - tq),    64'd1);
    rq = t_rise;
    // req_now held during WAIT must not add a strobe
    wait_cycles(20);
    dut_if.req_now = 1'b1;
    wait_cycles(30);
    dut_if.req_now = 1'b0;
    wait_new("req_poll", 200);
    check("req_wait_ignored", 64'(n_strobes - sc), 64'd1);

    // req_now coincident with period expiry: one poll only
    while (cyc < rq + 999) @(negedge clk1M);
    dut_if.req_now = 1'b1;
    @(negedge clk1M);
    dut_if.req_now = 1'b0;
    check("coinc_count", 64'(n_strobes - sc), 64'd2);
    check("coinc_time",  64'(t_rise - rq),    64'd1000);
    rc = t_rise;
    wait_rise("coinc_next", PERIOD + 100);
    check("coinc_next_period", 64'(t_rise - rc), 64'd1000);
    check("coinc_next_count",  64'(n_strobes - sc), 64'd3);
    rc2 = t_rise;

    // Reset mid-TRIG
    @(negedge clk1M);
    rst = 1'b1;
    #1;
    check("rst_trig_flag",  64'(dut_if.flag_five_sec), 64'd0);
    check("rst_trig_busy",  64'(dut_if.busy),          64'd0);
    check("rst_trig_hum",   64'(dut_if.hum_int),       64'd0);
    check("rst_trig_valid", 64'(dut_if.data_valid),    64'd0);
    check("rst_trig_err",   64'(dut_if.err_count),     64'd0);
    wait_cycles(2);
    rst = 1'b0;
    t0  = cyc;
    wait_rise("rst_trig_next", PERIOD + 100);
    check("rst_trig_period", 64'(t_rise - t0), 64'd1000);
    r8 = t_rise;

    // Reset mid-WAIT
    wait_cycles(50);
    rst = 1'b1;
    #1;
    check("rst_wait_flag", 64'(dut_if.flag_five_sec), 64'd0);
    check("rst_wait_busy", 64'(dut_if.busy),          64'd0);
    wait_cycles(2);
    rst = 1'b0;
    t0  = cyc;
    wait_rise("rst_wait_next", PERIOD + 100);
    check("rst_wait_period", 64'(t_rise - t0), 64'd1000);
    r9 = t_rise;

    // No sensor: line stuck high, frame zero -> 1 + MAX_RETRY strobes
    n_edges = 0;
    dut_if.frame = '0;
    sc = n_strobes;
    nn = n_new;
    wait_rise("nos_retry1", 400);
    check("nos_retry1_gap", 64'(t_rise - r9), 64'd301);
    r10 = t_rise;
    wait_rise("nos_retry2", 400);
    check("nos_retry2_gap", 64'(t_rise - r10), 64'd301);
    r11 = t_rise;
    wait_cycles(102);
    check("nos_err",   64'(dut_if.err_count),  64'd3);
    check("nos_valid", 64'(dut_if.data_valid), 64'd0);
    check("nos_hum",   64'(dut_if.hum_int),    64'd0);
    check("nos_temp",  64'(dut_if.temp_int),   64'd0);
    check("nos_idle",  64'(dut_if.busy),       64'd0);
    check("nos_no_new", 64'(n_new - nn),       64'd0);
    wait_cycles(800);
    check("nos_gave_up", 64'(n_strobes - sc),  64'd2);
    check("nos_still_idle", 64'(dut_if.busy),  64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
